// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver: time-multiplexed driver for DIGITS common-anode 7-segment digits.
// A shadow copy of value/dp (and blink) is latched on load. The digits are then scanned one
// slot at a time. Each slot opens with GUARD cycles of all anodes off to avoid ghosting.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         latch value/dp/blink into the shadow registers
//   value        packed nibbles, digit 0 in [3:0]
//   dp           per-digit decimal point request (1 = lit)
//   blink        per-digit blink request (only used with SEVENSEG_BLINK_EN)
//   hex_mode     1 = hex glyphs for 10-15, 0 = those nibbles show blank
//   blank_lz     1 = blank leading zeros (digit 0 always shown)
//   ledsegments  gfedcba, active-low
//   dp_n         decimal point segment, active-low
//   an_n         digit anodes, active-low, at most one low
//
// Build option: define SEVENSEG_BLINK_EN to enable per-digit blinking. The blink phase
// toggles every BLINK_FRAMES complete scan frames.
module sevenseg_scan_driver #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD        = 2,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blink,
  input  logic                hex_mode,
  input  logic                blank_lz,
  output logic [6:0]          ledsegments,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an_n
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam logic [CntW-1:0] CntLast  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntGuard = CntW'(GUARD);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DIGITS - 1);

  logic [CntW-1:0]     cnt_q;
  logic [IdxW-1:0]     idx_q;
  logic [4*DIGITS-1:0] sh_value_q;
  logic [DIGITS-1:0]   sh_dp_q;
  logic                slot_end;

  assign slot_end = (cnt_q == CntLast);

  function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
    logic [6:0] seg;
    case (n)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = hex ? 7'h08 : 7'h7F;
      4'hB:    seg = hex ? 7'h03 : 7'h7F;
      4'hC:    seg = hex ? 7'h46 : 7'h7F;
      4'hD:    seg = hex ? 7'h21 : 7'h7F;
      4'hE:    seg = hex ? 7'h06 : 7'h7F;
      default: seg = hex ? 7'h0E : 7'h7F;
    endcase
    return seg;
  endfunction

  // lz[k] is set when every nibble from the top digit down to k is zero.
  logic [DIGITS-1:0] lz;
  always_comb begin
    logic zrun;
    zrun = 1'b1;
    lz   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zrun  = zrun & (sh_value_q[4*k +: 4] == 4'h0);
      lz[k] = zrun;
    end
  end

  logic [3:0] nib;
  logic       dp_sel;
  logic       lz_sel;
  logic       blanked;
  always_comb begin
    nib    = '0;
    dp_sel = 1'b0;
    lz_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IdxW'(k)) begin
        nib    = sh_value_q[4*k +: 4];
        dp_sel = sh_dp_q[k];
        lz_sel = lz[k];
      end
    end
  end

  assign blanked = blank_lz & lz_sel & (idx_q != '0);

`ifdef SEVENSEG_BLINK_EN
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

  logic [FrameW-1:0] frame_q;
  logic              phase_q;
  logic [DIGITS-1:0] sh_blink_q;
  logic              blink_sel;

  always_comb begin
    blink_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IdxW'(k)) blink_sel = sh_blink_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q    <= '0;
      phase_q    <= 1'b0;
      sh_blink_q <= '0;
    end else begin
      if (load) sh_blink_q <= blink;
      if (slot_end && (idx_q == IdxLast)) begin
        if (frame_q == FrameLast) begin
          frame_q <= '0;
          phase_q <= ~phase_q;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
    end
  end
`else
  logic unused_blink;
  assign unused_blink = ^{blink, BLINK_FRAMES[0]};
`endif

  logic [DIGITS-1:0] an_d;
  logic [6:0]        seg_d;
  logic              dpn_d;
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dpn_d = 1'b1;
    if (cnt_q >= CntGuard) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (idx_q == IdxW'(k)) an_d[k] = 1'b0;
      end
      // A blanked digit keeps its anode so the slot duty stays uniform.
      if (!blanked) begin
        seg_d = decode(nib, hex_mode);
        dpn_d = ~dp_sel;
      end
`ifdef SEVENSEG_BLINK_EN
      if (phase_q && blink_sel) an_d = '1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_value_q  <= '0;
      sh_dp_q     <= '0;
      an_n        <= '1;
      ledsegments <= 7'h7F;
      dp_n        <= 1'b1;
    end else begin
      cnt_q <= slot_end ? '0 : cnt_q + 1'b1;
      if (slot_end) idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      if (load) begin
        sh_value_q <= value;
        sh_dp_q    <= dp;
      end
      an_n        <= an_d;
      ledsegments <= seg_d;
      dp_n        <= dpn_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver with DIGITS=4, SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2.
// "s" is the scan state reflected on the pins: after edge t since reset release the pins
// show state t-1, i.e. cnt = s%8, idx = (s/8)%4.
module tb_sevenseg_scan_driver;
  localparam int NV = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blink = '0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  ledsegments;
  logic        dp_n;
  logic [3:0]  an_n;

  int total = 0;
  int bad   = 0;
  int cyc;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            hex;
    logic            blz;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
  } vec_t;

  vec_t        vec[NV];
  logic [11:0] sb[$];

  sevenseg_scan_driver #(
    .DIGITS      (4),
    .SCAN_DIV    (8),
    .GUARD       (2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .blink      (blink),
    .hex_mode   (hex_mode),
    .blank_lz   (blank_lz),
    .ledsegments(ledsegments),
    .dp_n       (dp_n),
    .an_n       (an_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got an/dp/seg=%h want %h", name, got, want);
    end
  endtask

  task automatic wait_state(input int s);
    int n = 0;
    @(negedge clk);
    while ((cyc - 1) != s && n < 400) begin
      @(negedge clk);
      n++;
    end
    if ((cyc - 1) != s) begin
      total++;
      bad++;
      $display("FAIL wait_state: got state %0d want %0d", cyc - 1, s);
    end
  endtask

  // Wait for the first lit cycle of digit k's next slot.
  task automatic next_slot(input int k);
    int cur, t;
    cur = cyc - 1;
    t = cur - (cur % 32) + k * 8 + 2;
    if (t <= cur) t += 32;
    wait_state(t);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    @(negedge clk);
    value = v;
    dp    = d;
    blink = b;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    logic [11:0] e;
    logic [3:0]  an_e;
    int          s, t, cur;

    vec[0] = '{16'h1290, 4'b0100, 1'b0, 1'b0, {7'h79, 7'h24, 7'h10, 7'h40}, 4'b1011};
    vec[1] = '{16'hFEDA, 4'b0000, 1'b1, 1'b0, {7'h0E, 7'h06, 7'h21, 7'h08}, 4'b1111};
    vec[2] = '{16'hFEDA, 4'b0000, 1'b0, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};
    vec[3] = '{16'h0050, 4'b0000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vec[4] = '{16'h0000, 4'b0000, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vec[5] = '{16'h0345, 4'b1000, 1'b0, 1'b1, {7'h7F, 7'h30, 7'h19, 7'h12}, 4'b1111};
    vec[6] = '{16'h6B78, 4'b0001, 1'b1, 1'b0, {7'h02, 7'h03, 7'h78, 7'h00}, 4'b1110};
    vec[7] = '{16'hC0C0, 4'b0000, 1'b1, 1'b1, {7'h46, 7'h40, 7'h46, 7'h40}, 4'b1111};
    vec[8] = '{16'h0000, 4'b0001, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {an_n, dp_n, ledsegments}, {4'hF, 1'b1, 7'h7F});

    // Scan pattern after release, value 0
    rst_n = 1'b1;
    for (int i = 0; i < 72; i++) begin
      @(negedge clk);
      s = cyc - 1;
      if ((s % 8) >= 2) e = {~(4'b0001 << ((s / 8) % 4)), 1'b1, 7'h40};
      else              e = {4'hF, 1'b1, 7'h7F};
      check($sformatf("scan s=%0d", s), {an_n, dp_n, ledsegments}, e);
    end

    // Table of decode vectors through the scoreboard
    for (int i = 0; i < NV; i++) begin
      hex_mode = vec[i].hex;
      blank_lz = vec[i].blz;
      pulse_load(vec[i].value, vec[i].dp, 4'b0000);
      for (int k = 0; k < 4; k++) sb.push_back({~(4'b0001 << k), vec[i].dpn[k], vec[i].seg[k]});
      for (int k = 0; k < 4; k++) begin
        next_slot(k);
        e = sb.pop_front();
        check($sformatf("vec%0d digit%0d", i, k), {an_n, dp_n, ledsegments}, e);
      end
    end

    // Load latency: new glyph appears one edge after the latching edge
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    pulse_load(16'h0000, 4'b0000, 4'b0000);
    next_slot(0);
    check("latency_before", {an_n, dp_n, ledsegments}, {4'hE, 1'b1, 7'h40});
    value = 16'h0005;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("latency_edgeE", {an_n, dp_n, ledsegments}, {4'hE, 1'b1, 7'h40});
    @(negedge clk);
    check("latency_edgeE1", {an_n, dp_n, ledsegments}, {4'hE, 1'b1, 7'h12});

    // Load held high: scanning unaffected
    value = 16'h0007;
    load  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_slot(k);
      check($sformatf("load_held digit%0d", k), {an_n, dp_n, ledsegments},
            {~(4'b0001 << k), 1'b1, (k == 0) ? 7'h78 : 7'h40});
    end
    load = 1'b0;

    // Async reset mid-slot at cnt=5, idx=2
    pulse_load(16'h1290, 4'b0000, 4'b0000);
    cur = cyc - 1;
    t = cur - (cur % 32) + 20;
    if (t <= cur) t += 32;
    wait_state(t);
    check("pre_reset_digit2", {an_n, dp_n, ledsegments}, {4'hB, 1'b1, 7'h24});
    rst_n = 1'b0;
    #1;
    check("async_reset", {an_n, dp_n, ledsegments}, {4'hF, 1'b1, 7'h7F});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_guard", {an_n, dp_n, ledsegments}, {4'hF, 1'b1, 7'h7F});
    next_slot(0);
    check("restart_digit0", {an_n, dp_n, ledsegments}, {4'hE, 1'b1, 7'h40});
    check("restart_state", cyc - 1, 2);
    next_slot(2);
    check("restart_shadow_clear", {an_n, dp_n, ledsegments}, {4'hB, 1'b1, 7'h40});

    // Blink: frames counted from reset release
    rst_n = 1'b0;
    @(negedge clk);
    value = 16'h0000;
    blink = 4'b0010;
    load  = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    for (int f = 0; f < 6; f++) begin
      wait_state(f * 32 + 2);
      check($sformatf("blink f%0d digit0", f), {an_n, dp_n, ledsegments}, {4'hE, 1'b1, 7'h40});
      wait_state(f * 32 + 10);
`ifdef SEVENSEG_BLINK_EN
      an_e = (((f / 2) % 2) == 1) ? 4'hF : 4'hD;
`else
      an_e = 4'hD;
`endif
      check($sformatf("blink f%0d digit1", f), {an_n, dp_n, ledsegments}, {an_e, 1'b1, 7'h40});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
